// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the fetch-side blocks: major opcodes, the
// canonical NOP word and the immediate-format classification helper.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  // addi x0,x0,0
  localparam logic [31:0] OP_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // Immediate layout implied by the major opcode; unknown opcodes carry no
  // immediate and are treated like R-type.
  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: f = FMT_I;
      OP_STORE:                            f = FMT_S;
      OP_BRANCH:                           f = FMT_B;
      OP_LUI, OP_AUIPC:                    f = FMT_U;
      OP_JAL:                              f = FMT_J;
      default:                             f = FMT_R;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32i_field_decode.sv
// Registered RV32I field splitter: one cycle after instr is presented the
// raw register/funct slices and the sign-extended immediate appear.
// Reset shows the decode of a NOP.
module rv32i_field_decode
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  fun3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  fun7,
  output logic [31:0] imm
);

  // Assemble the immediate for whichever format the opcode selects.
  function automatic logic signed [31:0] imm_gen(input logic [31:0] i);
    logic signed [31:0] r;
    case (fmt_of(i[6:0]))
      FMT_I:   r = {{20{i[31]}}, i[31:20]};
      FMT_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   r = {i[31:12], 12'b0};
      FMT_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [6:0]         opcode_p1;
  logic [4:0]         rd_p1;
  logic [2:0]         fun3_p1;
  logic [4:0]         rs1_p1;
  logic [4:0]         rs2_p1;
  logic [6:0]         fun7_p1;
  logic signed [31:0] imm_p1;

  // Stage p0 -> p1: capture slices and immediate every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_p1 <= OP_IMM;
      rd_p1     <= '0;
      fun3_p1   <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      fun7_p1   <= '0;
      imm_p1    <= '0;
    end else begin
      opcode_p1 <= instr[6:0];
      rd_p1     <= instr[11:7];
      fun3_p1   <= instr[14:12];
      rs1_p1    <= instr[19:15];
      rs2_p1    <= instr[24:20];
      fun7_p1   <= instr[31:25];
      imm_p1    <= imm_gen(instr);
    end
  end

  assign opcode = opcode_p1;
  assign rd     = rd_p1;
  assign fun3   = fun3_p1;
  assign rs1    = rs1_p1;
  assign rs2    = rs2_p1;
  assign fun7   = fun7_p1;
  assign imm    = imm_p1;

endmodule

// File: rtl/imem_decode.sv
// Fetch-stage instruction memory with a done flag plus a registered RV32I
// field decoder. Every word starts as a NOP and only the load port changes
// contents.
module imem_decode
  import rv32_pkg::*;
#(
  parameter int INS_SIZE  = 64,
  parameter     INIT_FILE = "imem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic        load,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        done,
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  fun3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  fun7,
  output logic [31:0] imm
);

  localparam int          AW    = (INS_SIZE > 1) ? $clog2(INS_SIZE) : 1;
  localparam logic [31:0] DEPTH = INS_SIZE;

  logic [31:0] mem [INS_SIZE] = '{default: OP_NOP};

  logic [29:0]   idx;
  logic [AW-1:0] widx;
  logic          in_range;
  logic [31:0]   last_adr;

  assign idx      = adr[31:2];
  assign widx     = idx[AW-1:0];
  assign in_range = ({2'b00, idx} < DEPTH);

  // Byte offset is ignored and the file name is not used.
  logic unused_bits;
  assign unused_bits = ^{adr[1:0], INIT_FILE};

  // Memory write: out-of-range addresses never alias onto a real word.
  always_ff @(posedge clk) begin
    if (load && in_range) begin
      mem[widx] <= in;
    end
  end

  // Read port: registered data, done once the address has been stable for
  // one edge with no write in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= OP_NOP;
      done     <= 1'b0;
      last_adr <= '0;
    end else begin
      last_adr <= adr;
      done     <= (adr == last_adr) && !load;
      if (!in_range) begin
        out <= OP_NOP;
      end else if (load) begin
        out <= in;
      end else begin
        out <= mem[widx];
      end
    end
  end

  rv32i_field_decode u_dec (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .opcode (opcode),
    .rd     (rd),
    .fun3   (fun3),
    .rs1    (rs1),
    .rs2    (rs2),
    .fun7   (fun7),
    .imm    (imm)
  );

endmodule

// File: tb/tb_imem_decode.sv
// Directed bench for imem_decode: memory write/read/done timing, out-of-range
// handling, async reset and immediate decoding for each instruction format.
module tb_imem_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic        load;
  logic [31:0] in;
  logic [31:0] out;
  logic        done;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  fun3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  fun7;
  logic [31:0] imm;

  int checks   = 0;
  int failures = 0;

  imem_decode #(.INS_SIZE(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .adr    (adr),
    .load   (load),
    .in     (in),
    .out    (out),
    .done   (done),
    .instr  (instr),
    .opcode (opcode),
    .rd     (rd),
    .fun3   (fun3),
    .rs1    (rs1),
    .rs2    (rs2),
    .fun7   (fun7),
    .imm    (imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] exp_out, input logic exp_done);
    check({tag, ".out"}, out, exp_out);
    check({tag, ".done"}, {31'b0, done}, {31'b0, exp_done});
  endtask

  initial begin
    rst = 1'b1; adr = '0; load = 1'b0; in = '0; instr = 32'h0000_0013;
    #2;
    rd_chk("reset", 32'h13, 1'b0);
    check("reset.opcode", {25'b0, opcode}, 32'h13);
    check("reset.imm", imm, 32'h0);
    #5 rst = 1'b0;

    // Seed words 0 and 1.
    adr = 32'd0; load = 1'b1; in = 32'h1111_1111;
    step(); rd_chk("wr0", 32'h1111_1111, 1'b0);
    adr = 32'd4; in = 32'h2222_2222;
    step(); rd_chk("wr1", 32'h2222_2222, 1'b0);

    // Write then hold the address with load low.
    adr = 32'd8; in = 32'hDEAD_BEEF;
    step(); rd_chk("wr2", 32'hDEAD_BEEF, 1'b0);
    load = 1'b0;
    step(); rd_chk("hold2a", 32'hDEAD_BEEF, 1'b1);
    step(); rd_chk("hold2b", 32'hDEAD_BEEF, 1'b1);

    // Address stepping: each change costs one done=0 cycle.
    adr = 32'd0;
    step(); check("step0.done", {31'b0, done}, 32'h0);
    step(); rd_chk("held0", 32'h1111_1111, 1'b1);
    adr = 32'd4;
    step(); check("step4.done", {31'b0, done}, 32'h0);
    step(); rd_chk("held4", 32'h2222_2222, 1'b1);
    adr = 32'd8;
    step(); check("step8.done", {31'b0, done}, 32'h0);
    step(); rd_chk("held8", 32'hDEAD_BEEF, 1'b1);
    adr = 32'd12;
    step(); step(); rd_chk("held12", 32'h13, 1'b1);

    // Byte offset ignored for indexing, but still a new address for done.
    adr = 32'd9;
    step(); rd_chk("adr9a", 32'hDEAD_BEEF, 1'b0);
    step(); rd_chk("adr9b", 32'hDEAD_BEEF, 1'b1);

    // Out of range: write attempt must not alias onto word 0.
    adr = 32'd256; load = 1'b1; in = 32'hBADB_AD00;
    step(); rd_chk("oor_wr", 32'h13, 1'b0);
    load = 1'b0;
    step(); rd_chk("oor_rd", 32'h13, 1'b1);
    adr = 32'd252;
    step(); step(); rd_chk("last_word", 32'h13, 1'b1);
    adr = 32'd0;
    step(); step(); rd_chk("no_alias", 32'h1111_1111, 1'b1);

    // Decoder: I-type addi sp,sp,-32.
    instr = 32'hFE01_0113;
    step();
    check("addi.opcode", {25'b0, opcode}, 32'h13);
    check("addi.rd", {27'b0, rd}, 32'd2);
    check("addi.rs1", {27'b0, rs1}, 32'd2);
    check("addi.fun3", {29'b0, fun3}, 32'd0);
    check("addi.fun7", {25'b0, fun7}, 32'h7F);
    check("addi.imm", imm, 32'hFFFF_FFE0);

    instr = 32'hFE5F_F0EF;
    step(); check("jal.imm", imm, 32'hFFFF_FFE4);
    instr = 32'h00A1_2223;
    step(); check("sw.imm", imm, 32'h0000_0004);
    // beq x0,x0,-4: bit 7 set so imm[11] is 1.
    instr = 32'hFE00_0EE3;
    step(); check("beq.imm", imm, 32'hFFFF_FFFC);
    // Same branch with bit 7 clear -> imm[11] drops.
    instr = 32'hFE00_0E63;
    step(); check("beq2.imm", imm, 32'hFFFF_F7FC);
    instr = 32'h1234_52B7;
    step();
    check("lui.opcode", {25'b0, opcode}, 32'h37);
    check("lui.imm", imm, 32'h1234_5000);
    instr = 32'h0000_1097;
    step(); check("auipc.imm", imm, 32'h0000_1000);
    // R-type add a0,a0,a1: raw slices, no immediate.
    instr = 32'h00B5_0533;
    step();
    check("add.rd", {27'b0, rd}, 32'd10);
    check("add.rs1", {27'b0, rs1}, 32'd10);
    check("add.rs2", {27'b0, rs2}, 32'd11);
    check("add.imm", imm, 32'h0);

    // Mid-run async reset with non-NOP state on both halves.
    adr = 32'd8; instr = 32'h1234_52B7;
    step(); step();
    rd_chk("pre_rst", 32'hDEAD_BEEF, 1'b1);
    rst = 1'b1;
    #1;
    rd_chk("mid_rst", 32'h13, 1'b0);
    check("mid_rst.opcode", {25'b0, opcode}, 32'h13);
    check("mid_rst.imm", imm, 32'h0);
    #2 rst = 1'b0;
    // Memory survives reset; last_adr restarted at 0 so adr=8 is new.
    step(); rd_chk("post_rst", 32'hDEAD_BEEF, 1'b0);
    step(); rd_chk("post_rst2", 32'hDEAD_BEEF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
